// File: rtl/glip_uart_ctrl_filter.sv
// Ingress byte filter: strips MARKER-escaped control sequences (credit grants, resets)
// from a byte stream and forwards user bytes through a one-entry output register.
module glip_uart_ctrl_filter #(
    parameter logic [7:0]  MARKER       = 8'hFE,
    parameter int unsigned CREDIT_BYTES = 1,
    parameter int unsigned ERRCNT_WIDTH = 8,
    localparam int unsigned CREDIT_WIDTH = 6 + 8 * CREDIT_BYTES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    transfer,
    output logic                    credit_en,
    output logic [CREDIT_WIDTH-1:0] credit_val,
    output logic                    logic_rst_en,
    output logic                    logic_rst_val,
    output logic                    com_rst_en,
    output logic                    com_rst_val,
    output logic                    error,
    output logic [ERRCNT_WIDTH-1:0] error_count
);

    localparam int unsigned PayW    = 8 * CREDIT_BYTES;
    localparam logic [1:0]  CntLast = 2'(CREDIT_BYTES - 1);

    typedef enum logic [1:0] {StPass, StMatch, StCredit} state_e;

    state_e                  state_q, state_d;
    logic [5:0]              hdr_q, hdr_d;
    logic [PayW-1:0]         pay_q, pay_d, pay_next;
    logic [1:0]              cnt_q, cnt_d;
    logic [7:0]              out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    credit_en_q, credit_en_d;
    logic [CREDIT_WIDTH-1:0] credit_val_q, credit_val_d;
    logic                    lrst_en_q, lrst_en_d, lrst_val_q, lrst_val_d;
    logic                    crst_en_q, crst_en_d, crst_val_q, crst_val_d;
    logic                    error_q, error_d;
    logic [ERRCNT_WIDTH-1:0] errcnt_q, errcnt_d;
    logic                    accept, fwd;

    assign in_ready = ~out_valid_q | out_ready;
    assign accept   = in_valid & in_ready;
    // Credit payload shifts in MSB-first; the oldest byte falls off the top.
    assign pay_next = PayW'({pay_q, in_data});

    always_comb begin
        state_d      = state_q;
        hdr_d        = hdr_q;
        pay_d        = pay_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q & ~out_ready;
        out_data_d   = out_data_q;
        credit_en_d  = 1'b0;
        credit_val_d = credit_val_q;
        lrst_en_d    = 1'b0;
        lrst_val_d   = lrst_val_q;
        crst_en_d    = 1'b0;
        crst_val_d   = crst_val_q;
        error_d      = 1'b0;
        fwd          = 1'b0;
        if (accept) begin
            case (state_q)
                StPass: begin
                    if (in_data == MARKER) state_d = StMatch;
                    else                   fwd     = 1'b1;
                end
                StMatch: begin
                    state_d = StPass;
                    if (!in_data[0]) begin
                        if (in_data == MARKER) fwd     = 1'b1;
                        else                   error_d = 1'b1;
                    end else if (!in_data[7]) begin
                        hdr_d   = in_data[6:1];
                        cnt_d   = 2'd0;
                        state_d = StCredit;
                    end else begin
                        if (in_data[2]) begin
                            crst_en_d  = 1'b1;
                            crst_val_d = in_data[1];
                        end else begin
                            lrst_en_d  = 1'b1;
                            lrst_val_d = in_data[1];
                        end
                        error_d = |in_data[6:3];
                    end
                end
                StCredit: begin
                    pay_d = pay_next;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == CntLast) begin
                        credit_en_d  = 1'b1;
                        credit_val_d = {hdr_q, pay_next};
                        state_d      = StPass;
                    end
                end
                default: state_d = StPass;
            endcase
        end
        if (fwd) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data;
        end
        errcnt_d = errcnt_q;
        if (error_d && !(&errcnt_q)) errcnt_d = errcnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StPass;
            hdr_q        <= '0;
            pay_q        <= '0;
            cnt_q        <= '0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            credit_en_q  <= 1'b0;
            credit_val_q <= '0;
            lrst_en_q    <= 1'b0;
            lrst_val_q   <= 1'b0;
            crst_en_q    <= 1'b0;
            crst_val_q   <= 1'b0;
            error_q      <= 1'b0;
            errcnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            hdr_q        <= hdr_d;
            pay_q        <= pay_d;
            cnt_q        <= cnt_d;
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            credit_en_q  <= credit_en_d;
            credit_val_q <= credit_val_d;
            lrst_en_q    <= lrst_en_d;
            lrst_val_q   <= lrst_val_d;
            crst_en_q    <= crst_en_d;
            crst_val_q   <= crst_val_d;
            error_q      <= error_d;
            errcnt_q     <= errcnt_d;
        end
    end

    assign out_data      = out_data_q;
    assign out_valid     = out_valid_q;
    assign transfer      = out_valid_q & out_ready;
    assign credit_en     = credit_en_q;
    assign credit_val    = credit_val_q;
    assign logic_rst_en  = lrst_en_q;
    assign logic_rst_val = lrst_val_q;
    assign com_rst_en    = crst_en_q;
    assign com_rst_val   = crst_val_q;
    assign error         = error_q;
    assign error_count   = errcnt_q;

endmodule

// File: tb/tb_glip_uart_ctrl_filter.sv
// Directed bench for glip_uart_ctrl_filter: one DUT with 1 credit byte, one with 2.
module tb_glip_uart_ctrl_filter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid, in_valid2, out_ready, out_ready2;

    logic        in_ready, out_valid, transfer, credit_en, lrst_en, lrst_val;
    logic        crst_en, crst_val, error;
    logic [7:0]  out_data, error_count;
    logic [13:0] credit_val;

    logic        in_ready2, out_valid2, transfer2, credit_en2, lrst_en2, lrst_val2;
    logic        crst_en2, crst_val2, error2;
    logic [7:0]  out_data2, error_count2;
    logic [21:0] credit_val2;

    int n_chk = 0;
    int n_bad = 0;

    // Monitor state
    logic [7:0]  q_out[$];
    int          n_outv, n_credit, n_lrst, n_crst, n_err, n_stall, n_rule;
    int          n_credit2, n_out2;
    logic [13:0] last_credit;
    logic [21:0] last_credit2;
    logic        last_lrst_val, last_crst_val;

    glip_uart_ctrl_filter u_dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .transfer(transfer), .credit_en(credit_en), .credit_val(credit_val),
        .logic_rst_en(lrst_en), .logic_rst_val(lrst_val), .com_rst_en(crst_en),
        .com_rst_val(crst_val), .error(error), .error_count(error_count)
    );

    glip_uart_ctrl_filter #(.CREDIT_BYTES(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid2), .in_ready(in_ready2),
        .out_data(out_data2), .out_valid(out_valid2), .out_ready(out_ready2),
        .transfer(transfer2), .credit_en(credit_en2), .credit_val(credit_val2),
        .logic_rst_en(lrst_en2), .logic_rst_val(lrst_val2), .com_rst_en(crst_en2),
        .com_rst_val(crst_val2), .error(error2), .error_count(error_count2)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the falling edge, so sampling here is race-free.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid) n_outv++;
            if (out_valid && out_ready) q_out.push_back(out_data);
            if (transfer !== (out_valid & out_ready)) n_rule++;
            if (in_ready !== (~out_valid | out_ready)) n_rule++;
            if (out_valid && !out_ready && !in_ready) n_stall++;
            if (credit_en) begin n_credit++; last_credit = credit_val; end
            if (lrst_en) begin n_lrst++; last_lrst_val = lrst_val; end
            if (crst_en) begin n_crst++; last_crst_val = crst_val; end
            if (error) n_err++;
            if (credit_en2) begin n_credit2++; last_credit2 = credit_val2; end
            if (out_valid2) n_out2++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic clear_mon();
        q_out.delete();
        n_outv = 0; n_credit = 0; n_lrst = 0; n_crst = 0; n_err = 0; n_stall = 0;
        n_rule = 0; n_credit2 = 0; n_out2 = 0;
        last_credit = '0; last_credit2 = '0; last_lrst_val = 1'b0; last_crst_val = 1'b1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic send(input logic [7:0] b);
        int guard = 0;
        bit acc = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        while (!acc && guard < 50) begin
            #1;
            acc = in_ready;
            cyc(1);
            guard++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            n_chk++; n_bad++;
            $display("FAIL send_timeout: byte %02h not accepted in 50 cycles", b);
        end
    endtask

    task automatic send2(input logic [7:0] b);
        int guard = 0;
        bit acc = 1'b0;
        in_data   = b;
        in_valid2 = 1'b1;
        while (!acc && guard < 50) begin
            #1;
            acc = in_ready2;
            cyc(1);
            guard++;
        end
        in_valid2 = 1'b0;
        if (!acc) begin
            n_chk++; n_bad++;
            $display("FAIL send2_timeout: byte %02h not accepted in 50 cycles", b);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(2);
        n_chk++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_chk++; if (out_data !== 8'h00) begin n_bad++; $display("FAIL rst_out_data: got %02h want 00", out_data); end
        n_chk++; if (credit_val !== 14'h0) begin n_bad++; $display("FAIL rst_credit_val: got %h want 0", credit_val); end
        n_chk++; if ({credit_en, lrst_en, crst_en, error} !== 4'b0) begin n_bad++; $display("FAIL rst_pulses: got %b want 0000", {credit_en, lrst_en, crst_en, error}); end
        n_chk++; if ({lrst_val, crst_val} !== 2'b0) begin n_bad++; $display("FAIL rst_vals: got %b want 00", {lrst_val, crst_val}); end
        n_chk++; if (error_count !== 8'h00) begin n_bad++; $display("FAIL rst_errcnt: got %0d want 0", error_count); end
        n_chk++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic test_escape();
        logic [7:0] exp[3];
        exp = '{8'h41, 8'hFE, 8'h42};
        apply_reset();
        send(8'h41);
        n_chk++; if (out_valid !== 1'b1 || out_data !== 8'h41) begin n_bad++; $display("FAIL latency1: got v=%b d=%02h want v=1 d=41", out_valid, out_data); end
        send(8'hFE); send(8'hFE); send(8'h42);
        cyc(3);
        n_chk++; if (q_out.size() != 3) begin n_bad++; $display("FAIL escape_count: got %0d want 3", q_out.size()); end
        for (int i = 0; i < 3 && i < q_out.size(); i++) begin
            n_chk++; if (q_out[i] !== exp[i]) begin n_bad++; $display("FAIL escape_byte%0d: got %02h want %02h", i, q_out[i], exp[i]); end
        end
        n_chk++; if (n_err != 0) begin n_bad++; $display("FAIL escape_no_error: got %0d want 0", n_err); end
    endtask

    task automatic test_credit();
        apply_reset();
        send(8'hFE); send(8'h0B); send(8'h34);
        n_chk++; if (credit_en !== 1'b1 || credit_val !== 14'h0534) begin n_bad++; $display("FAIL credit1_pulse: got en=%b val=%h want en=1 val=0534", credit_en, credit_val); end
        cyc(3);
        n_chk++; if (n_credit != 1) begin n_bad++; $display("FAIL credit1_width: got %0d cycles want 1", n_credit); end
        n_chk++; if (credit_val !== 14'h0534) begin n_bad++; $display("FAIL credit1_hold: got %h want 0534", credit_val); end
        n_chk++; if (n_outv != 0) begin n_bad++; $display("FAIL credit1_no_out: got %0d want 0", n_outv); end
        // MARKER inside the payload is data, not an escape
        send(8'hFE); send(8'h01); send(8'hFE);
        cyc(3);
        n_chk++; if (n_credit != 2 || last_credit !== 14'h00FE) begin n_bad++; $display("FAIL credit_marker: got n=%0d val=%h want n=2 val=00fe", n_credit, last_credit); end
        n_chk++; if (n_outv != 0) begin n_bad++; $display("FAIL credit_marker_no_out: got %0d want 0", n_outv); end
    endtask

    task automatic test_credit2();
        apply_reset();
        send2(8'hFE); send2(8'h03); send2(8'h12); send2(8'h34);
        cyc(3);
        n_chk++; if (n_credit2 != 1 || last_credit2 !== 22'h011234) begin n_bad++; $display("FAIL credit2: got n=%0d val=%h want n=1 val=011234", n_credit2, last_credit2); end
        n_chk++; if (n_out2 != 0) begin n_bad++; $display("FAIL credit2_no_out: got %0d want 0", n_out2); end
    endtask

    task automatic test_ctrl();
        apply_reset();
        send(8'hFE); send(8'h83);
        cyc(3);
        n_chk++; if (n_lrst != 1 || last_lrst_val !== 1'b1) begin n_bad++; $display("FAIL logic_rst: got n=%0d val=%b want n=1 val=1", n_lrst, last_lrst_val); end
        send(8'hFE); send(8'h85);
        cyc(3);
        n_chk++; if (n_crst != 1 || last_crst_val !== 1'b0) begin n_bad++; $display("FAIL com_rst: got n=%0d val=%b want n=1 val=0", n_crst, last_crst_val); end
        n_chk++; if (n_err != 0 || n_lrst != 1) begin n_bad++; $display("FAIL ctrl_clean: got err=%0d lrst=%0d want 0/1", n_err, n_lrst); end
        send(8'hFE); send(8'h8B);
        cyc(3);
        n_chk++; if (n_lrst != 2 || n_err != 1 || n_crst != 1) begin n_bad++; $display("FAIL ctrl_badbits: got lrst=%0d err=%0d crst=%0d want 2/1/1", n_lrst, n_err, n_crst); end
        n_chk++; if (n_outv != 0) begin n_bad++; $display("FAIL ctrl_no_out: got %0d want 0", n_outv); end
    endtask

    task automatic test_error_sat();
        apply_reset();
        send(8'hFE); send(8'h02);
        cyc(3);
        n_chk++; if (n_err != 1 || error_count !== 8'd1) begin n_bad++; $display("FAIL error_once: got pulses=%0d cnt=%0d want 1/1", n_err, error_count); end
        n_chk++; if (n_outv != 0) begin n_bad++; $display("FAIL error_no_out: got %0d want 0", n_outv); end
        for (int i = 0; i < 299; i++) begin send(8'hFE); send(8'h02); end
        cyc(3);
        n_chk++; if (error_count !== 8'hFF) begin n_bad++; $display("FAIL error_sat: got %0d want 255", error_count); end
        n_chk++; if (n_err != 300) begin n_bad++; $display("FAIL error_pulses: got %0d want 300", n_err); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        fork
            begin
                for (int i = 0; i < 10; i++) send(8'h10 + 8'(i));
            end
            begin
                repeat (2) @(negedge clk);
                #1 out_ready = 1'b0;
                repeat (5) @(negedge clk);
                #1 out_ready = 1'b1;
            end
        join
        cyc(3);
        n_chk++; if (q_out.size() != 10) begin n_bad++; $display("FAIL b2b_count: got %0d want 10", q_out.size()); end
        for (int i = 0; i < 10 && i < q_out.size(); i++) begin
            n_chk++; if (q_out[i] !== 8'h10 + 8'(i)) begin n_bad++; $display("FAIL b2b_byte%0d: got %02h want %02h", i, q_out[i], 8'h10 + 8'(i)); end
        end
        n_chk++; if (n_stall != 5) begin n_bad++; $display("FAIL b2b_stall: got %0d want 5", n_stall); end
        n_chk++; if (n_rule != 0) begin n_bad++; $display("FAIL ready_rule: got %0d violations want 0", n_rule); end
    endtask

    task automatic test_trailing_marker();
        apply_reset();
        send(8'hFE);
        cyc(10);
        n_chk++; if (n_outv != 0 || n_err != 0) begin n_bad++; $display("FAIL trail_idle: got out=%0d err=%0d want 0/0", n_outv, n_err); end
        send(8'hFE);
        cyc(3);
        n_chk++; if (q_out.size() != 1 || q_out[0] !== 8'hFE) begin n_bad++; $display("FAIL trail_literal: got n=%0d want one FE byte", q_out.size()); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        send(8'hFE); send(8'h02); send(8'hFE); send(8'h0B);
        cyc(2);
        rst = 1'b1;
        #1;
        n_chk++; if (error_count !== 8'h00) begin n_bad++; $display("FAIL rst_async_errcnt: got %0d want 0", error_count); end
        cyc(1);
        rst = 1'b0;
        clear_mon();
        send(8'h41);
        cyc(3);
        n_chk++; if (n_credit != 0) begin n_bad++; $display("FAIL rst_mid_no_credit: got %0d want 0", n_credit); end
        n_chk++; if (q_out.size() != 1 || q_out[0] !== 8'h41) begin n_bad++; $display("FAIL rst_mid_pass: got n=%0d want one 41 byte", q_out.size()); end
    endtask

    initial begin
        rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_valid2 = 1'b0;
        out_ready = 1'b1; out_ready2 = 1'b1;
        clear_mon();
        cyc(1);
        test_reset();
        test_escape();
        test_credit();
        test_credit2();
        test_ctrl();
        test_error_sat();
        test_back_to_back();
        test_trailing_marker();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", n_bad, n_chk);
        $finish;
    end

endmodule

// File: doc/glip_uart_ctrl_filter.md
GLIP_UART_CTRL_FILTER -- requirements
Module: glip_uart_ctrl_filter

Interface
REQ-001 Parameter MARKER, default 8'hFE, escape byte that opens a control sequence.
REQ-002 Parameter CREDIT_BYTES, default 1, legal range 1..3, number of payload bytes after the credit header.
REQ-003 Parameter ERRCNT_WIDTH, default 8, width of the saturating error counter.
REQ-004 Derived CREDIT_WIDTH = 6 + 8*CREDIT_BYTES; not overridable.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 in_data  in  8  ingress byte stream.
REQ-008 in_valid  in  1  in_data valid.
REQ-009 in_ready  out  1  byte accepted when in_valid & in_ready.
REQ-010 out_data  out  8  filtered user byte, registered.
REQ-011 out_valid  out  1  out_data valid, registered.
REQ-012 out_ready  in  1  downstream accepts when out_valid & out_ready.
REQ-013 transfer  out  1  equals out_valid & out_ready; used for credit counting.
REQ-014 credit_en / credit_val  out  1 / CREDIT_WIDTH  one-cycle credit grant pulse and value.
REQ-015 logic_rst_en / logic_rst_val  out  1 / 1  logic-reset control pulse and value.
REQ-016 com_rst_en / com_rst_val  out  1 / 1  communication-reset control pulse and value.
REQ-017 error  out  1  one-cycle pulse per protocol violation.
REQ-018 error_count  out  ERRCNT_WIDTH  saturating count of error pulses.

Function
REQ-019 The output stage SHALL be a one-entry register; in_ready = ~out_valid | out_ready in every state.
REQ-020 An accepted byte SHALL appear on out_data/out_valid in the cycle after acceptance (latency 1); out_valid holds with stable out_data until transfer.
REQ-021 The FSM SHALL have states PASS, MATCH, CREDIT; it advances only on accepted bytes.
REQ-022 PASS: a byte != MARKER is forwarded; a byte == MARKER is dropped and the FSM moves to MATCH.
REQ-023 MATCH, bit0 = 0: if the byte == MARKER it is forwarded as literal data; otherwise it is dropped and error pulses; PASS in both cases.
REQ-024 MATCH, bit0 = 1, bit7 = 0: header[6:1] is stored, the byte counter is cleared, and the FSM moves to CREDIT.
REQ-025 MATCH, bit0 = 1, bit7 = 1: bit2 = 0 selects logic_rst, bit2 = 1 selects com_rst; the selected *_en pulses with *_val = bit1; bits 6:3 nonzero SHALL additionally pulse error; PASS.
REQ-026 CREDIT: each accepted byte shifts into the credit register, first byte most significant; after CREDIT_BYTES bytes, credit_val = {header[6:1], payload bytes} and the FSM returns to PASS.
REQ-027 All control and error pulses SHALL be registered: asserted for exactly one cycle, in the cycle after the completing byte is accepted.
REQ-028 credit_val SHALL hold its last value outside credit_en pulses; its reset value is 0.
REQ-029 error_count SHALL increment on each error pulse and saturate at all-ones without wrapping.
REQ-030 Backpressure SHALL never drop or duplicate bytes; control bytes are consumed under the same in_ready rule.
REQ-031 A MARKER byte received in CREDIT SHALL be treated as credit payload, not as an escape.
REQ-032 A MARKER byte that is the final input byte SHALL leave the FSM in MATCH indefinitely with no output.

Reset
REQ-033 While rst is high: state = PASS; out_valid, credit_en, logic_rst_en, com_rst_en, error = 0; all *_val = 0; credit_val = 0; error_count = 0; out_data = 0.
REQ-034 Reset mid-sequence SHALL discard any partial control or credit sequence; no pulse is emitted after reset release.

Verification
REQ-035 Stream 41 FE FE 42 with out_ready = 1 -> out bytes 41 FE 42; no error.
REQ-036 CREDIT_BYTES = 1, stream FE 0B 34 -> one credit_en pulse with credit_val = 14'h0534; no out_valid.
REQ-037 CREDIT_BYTES = 2, stream FE 03 12 34 -> credit_val = 22'h011234.
REQ-038 Stream FE 83 then FE 85 -> logic_rst_en with val 1, then com_rst_en with val 0.
REQ-039 Stream FE 02 -> error pulse, error_count = 1, no output; 300 such pairs with ERRCNT_WIDTH = 8 -> error_count = 255.
REQ-040 Hold out_ready = 0 for 5 cycles during 10 data bytes -> in_ready low while the output register is full; all 10 bytes delivered in order.
